// File: rtl/mips_pkg.sv
// Shared widths, the HALT marker and the loader state type used by the
// instruction loader and its byte-to-word assembler.
package mips_pkg;

  localparam int NB_DATA = 32;
  localparam int NB_BYTE = 8;
  localparam int NB_ADDR = 7;

  localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_WRITE   = 3'd1,
    ST_REPORT  = 3'd2,
    ST_DONE    = 3'd3,
    ST_FULL    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: each accepted byte shifts in at the
// bottom, and word_valid flags the byte that completes a 32-bit word.
module word_assembler
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               take,
  input  logic [NB_BYTE-1:0] byte_in,
  output logic [NB_DATA-1:0] word,
  output logic               word_valid
);

  logic [1:0]         byte_cnt;
  logic [NB_DATA-1:0] shift_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (take) begin
      shift_reg <= {shift_reg[NB_DATA-NB_BYTE-1:0], byte_in};
      byte_cnt  <= byte_cnt + 2'd1;
    end
  end

  assign word       = shift_reg;
  assign word_valid = take && (byte_cnt == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Loads big-endian instruction words from the UART into instruction memory,
// stops on HALT or a full memory, then reports the word count over the UART.
module instr_loader
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic [NB_BYTE-1:0] rx_data_i,
  input  logic               rx_done_i,
  input  logic               tx_busy_i,
  output logic               mem_wr_en_o,
  output logic [NB_ADDR-1:0] mem_addr_o,
  output logic [NB_DATA-1:0] mem_data_o,
  output logic               tx_start_o,
  output logic [NB_BYTE-1:0] tx_data_o,
  output logic [NB_ADDR:0]   word_count_o,
  output logic               load_done_o,
  output logic               overflow_o
);

  loader_state_t      state, state_nx;
  logic [NB_ADDR-1:0] addr;
  logic [NB_ADDR:0]   word_count;
  logic               halt_seen;
  logic [NB_BYTE-1:0] tx_data;

  logic               take;
  logic               wr_en;
  logic               tx_start;
  logic [NB_DATA-1:0] word;
  logic               word_valid;
  logic               is_halt;
  logic               last_addr;

  word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_i),
    .take       (take),
    .byte_in    (rx_data_i),
    .word       (word),
    .word_valid (word_valid)
  );

  assign is_halt   = (word == HALT_WORD);
  assign last_addr = (addr == '1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    wr_en    = 1'b0;
    tx_start = 1'b0;
    case (state)
      ST_COLLECT: begin
        take = rx_done_i;
        if (word_valid) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        if (is_halt || last_addr) begin
          state_nx = ST_REPORT;
        end else begin
          // Back-to-back streams: a byte landing during the write starts the next word.
          state_nx = ST_COLLECT;
          take     = rx_done_i;
        end
      end
      ST_REPORT: begin
        if (!tx_busy_i) begin
          tx_start = 1'b1;
          state_nx = halt_seen ? ST_DONE : ST_FULL;
        end
      end
      ST_DONE:  state_nx = ST_DONE;
      ST_FULL:  state_nx = ST_FULL;
      default:  state_nx = ST_COLLECT;
    endcase
    if (clear_i) begin
      state_nx = ST_COLLECT;
      take     = 1'b0;
      wr_en    = 1'b0;
      tx_start = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      word_count <= '0;
      halt_seen  <= 1'b0;
      tx_data    <= '0;
    end else begin
      if (clear_i) begin
        addr       <= '0;
        word_count <= '0;
        halt_seen  <= 1'b0;
      end else if (wr_en) begin
        word_count <= word_count + 1'b1;
        halt_seen  <= is_halt;
        // Address only advances when more words may follow, so it never wraps.
        if (state_nx == ST_COLLECT) addr <= addr + 1'b1;
      end
      if (tx_start) tx_data <= word_count[NB_BYTE-1:0];
    end
  end

  assign mem_wr_en_o  = wr_en;
  assign mem_addr_o   = addr;
  assign mem_data_o   = word;
  assign tx_start_o   = tx_start;
  assign tx_data_o    = tx_data;
  assign word_count_o = word_count;
  assign load_done_o  = (state == ST_DONE);
  assign overflow_o   = (state == ST_FULL);

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes expected memory writes and
// UART reports into queues; a negedge monitor pops and compares them.
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_done_i = 1'b0;
  logic        tx_busy_i = 1'b0;
  logic        mem_wr_en_o;
  logic [6:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic [7:0]  word_count_o;
  logic        load_done_o;
  logic        overflow_o;

  instr_loader dut (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (clear_i),
    .rx_data_i    (rx_data_i),
    .rx_done_i    (rx_done_i),
    .tx_busy_i    (tx_busy_i),
    .mem_wr_en_o  (mem_wr_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .tx_start_o   (tx_start_o),
    .tx_data_o    (tx_data_o),
    .word_count_o (word_count_o),
    .load_done_o  (load_done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
  } tx_t;

  wr_t wq[$];
  tx_t tq[$];
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, expected no event (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: every write / report strobe must match the head of its queue.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_wr_en_o && tx_start_o) flag("wr_and_tx_together", 1);
      if (mem_wr_en_o) begin
        if (wq.size() == 0) flag("unexpected_write", {mem_addr_o, mem_data_o});
        else begin
          wr_t e;
          e = wq.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("write_addr", mem_addr_o, e.addr);
          check("write_data", mem_data_o, e.data);
        end
      end
      if (tx_start_o) begin
        if (tq.size() == 0) flag("unexpected_tx_start", tx_data_o);
        else begin
          tx_t t;
          t = tq.pop_front();
          check("tx_cycle", cyc, t.cyc);
        end
      end
    end
  end

  // tx_data_o is registered on the pulse, so compare it the cycle after.
  logic       tx_seen = 1'b0;
  logic [7:0] tx_exp  = '0;
  always @(negedge clock) begin
    if (tx_seen) check("tx_data", tx_data_o, tx_exp);
    tx_seen = reset && tx_start_o;
    tx_exp  = word_count_o;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(posedge clock); #1;
    rx_done_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit exp_wr, input logic [6:0] a,
                           output int unsigned wcyc);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w;
      if (i == 3) wcyc = cyc + 1;
      send_byte(tmp[8*(3-i) +: 8]);
    end
    if (exp_wr) wq.push_back('{wcyc, a, w});
  endtask

  task automatic do_clear(input bit with_byte);
    clear_i = 1'b1;
    if (with_byte) begin
      rx_data_i = 8'hEE;
      rx_done_i = 1'b1;
    end
    @(posedge clock); #1;
    clear_i   = 1'b0;
    rx_done_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int unsigned w;
    #1 reset = 1'b0;
    idle(3);
    check("rst_wr_en", mem_wr_en_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", mem_data_o, 0);
    check("rst_tx_start", tx_start_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_count", word_count_o, 0);
    check("rst_flags", {load_done_o, overflow_o}, 0);
    reset = 1'b1;
    idle(2);

    // First word, then a HALT-terminated program with the transmitter free.
    send_word(32'h0000_4081, 1, 7'd0, w);
    idle(1);
    check("count_after_first", word_count_o, 1);
    send_word(32'h2001_0005, 1, 7'd1, w);
    send_word(32'hFFFF_FFFF, 1, 7'd2, w);
    tq.push_back('{w + 1, 8'h03});
    send_byte(8'h55);
    idle(2);
    check("halt_load_done", load_done_o, 1);
    check("halt_overflow", overflow_o, 0);
    check("halt_count", word_count_o, 3);
    send_word(32'h1122_3344, 0, 7'd0, w);
    idle(2);

    // HALT while the transmitter is busy for 10 cycles.
    do_clear(0);
    check("clear_flags", {load_done_o, overflow_o}, 0);
    check("clear_count", word_count_o, 0);
    tx_busy_i = 1'b1;
    send_word(32'hFFFF_FFFF, 1, 7'd0, w);
    repeat (10) begin
      @(posedge clock); #1;
      check("busy_no_done", load_done_o, 0);
    end
    tx_busy_i = 1'b0;
    tq.push_back('{cyc, 8'h01});
    idle(1);
    check("busy_done_after_pulse", load_done_o, 1);
    idle(2);

    // Fill all 128 words without HALT; a 129th word must not be written.
    do_clear(0);
    for (int i = 0; i < 128; i++) begin
      send_word(32'hA500_0000 | i, 1, i[6:0], w);
    end
    tq.push_back('{w + 1, 8'h80});
    send_word(32'hDEAD_BEEF, 0, 7'd0, w);
    idle(3);
    check("full_overflow", overflow_o, 1);
    check("full_load_done", load_done_o, 0);
    check("full_count", word_count_o, 8'h80);
    check("full_tx_data", tx_data_o, 8'h80);

    // Partial word discarded by clear; coincident byte dropped too.
    do_clear(0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    do_clear(1);
    send_word(32'h1234_5678, 1, 7'd0, w);
    idle(1);
    check("clear_partial_count", word_count_o, 1);

    // Asynchronous reset mid-word: outputs drop without a clock edge.
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    #2 reset = 1'b0;
    #1;
    check("async_count", word_count_o, 0);
    check("async_addr", mem_addr_o, 0);
    check("async_data", mem_data_o, 0);
    check("async_tx_data", tx_data_o, 0);
    idle(2);
    reset = 1'b1;
    idle(1);
    send_word(32'h0A0B_0C0D, 1, 7'd0, w);
    idle(5);

    check("pending_writes", wq.size(), 0);
    check("pending_reports", tq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
